// File: rtl/ewrapper_emesh_arbiter.sv
// Two-requester emesh arbiter feeding one link transmitter.
// Owner-based bursts with fairness after BURST_MAX; one registered output stage.
module ewrapper_emesh_arbiter #(
  parameter int BURST_MAX = 16
) (
  input  logic        emesh_clk_inb,
  input  logic        reset_n,
  input  logic        m0_access,
  input  logic        m0_write,
  input  logic [1:0]  m0_datamode,
  input  logic [3:0]  m0_ctrlmode,
  input  logic [31:0] m0_dstaddr,
  input  logic [31:0] m0_srcaddr,
  input  logic [31:0] m0_data,
  output logic        m0_wait,
  input  logic        m1_access,
  input  logic        m1_write,
  input  logic [1:0]  m1_datamode,
  input  logic [3:0]  m1_ctrlmode,
  input  logic [31:0] m1_dstaddr,
  input  logic [31:0] m1_srcaddr,
  input  logic [31:0] m1_data,
  output logic        m1_wait,
  output logic        emesh_access_outb,
  output logic        emesh_write_outb,
  output logic [1:0]  emesh_datamode_outb,
  output logic [3:0]  emesh_ctrlmode_outb,
  output logic [31:0] emesh_dstaddr_outb,
  output logic [31:0] emesh_srcaddr_outb,
  output logic [31:0] emesh_data_outb,
  input  logic        emesh_wr_wait_inb,
  input  logic        emesh_rd_wait_inb,
  output logic [1:0]  fsm_state,
  output logic [7:0]  burst_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t     state;
  logic       last;
  logic [7:0] cnt;
  logic       stall;
  logic       burst_open;
  logic       gnt_valid;
  logic       gnt_idx;
  logic       accept;

  // Handshake: a requester's transaction is taken on a cycle where its
  // access=1 and its wait=0; it must hold all fields stable while wait=1.
  always_comb begin
    stall = emesh_access_outb &
            (emesh_write_outb ? emesh_wr_wait_inb : emesh_rd_wait_inb);
  end

  always_comb begin
    burst_open = cnt < 8'(BURST_MAX);
  end

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = 1'b0;
    case (state)
      IDLE: begin
        if (m0_access && m1_access) begin
          gnt_valid = 1'b1;
          gnt_idx   = ~last;
        end else if (m0_access) begin
          gnt_valid = 1'b1;
          gnt_idx   = 1'b0;
        end else if (m1_access) begin
          gnt_valid = 1'b1;
          gnt_idx   = 1'b1;
        end
      end
      OWN0: begin
        if (m0_access && (burst_open || !m1_access)) begin
          gnt_valid = 1'b1;
          gnt_idx   = 1'b0;
        end else if (m1_access) begin
          gnt_valid = 1'b1;
          gnt_idx   = 1'b1;
        end
      end
      OWN1: begin
        if (m1_access && (burst_open || !m0_access)) begin
          gnt_valid = 1'b1;
          gnt_idx   = 1'b1;
        end else if (m0_access) begin
          gnt_valid = 1'b1;
          gnt_idx   = 1'b0;
        end
      end
      default: begin
        gnt_valid = 1'b0;
        gnt_idx   = 1'b0;
      end
    endcase
  end

  always_comb begin
    accept  = reset_n & ~stall & gnt_valid;
    m0_wait = ~reset_n | stall | (m0_access & ~(gnt_valid & ~gnt_idx));
    m1_wait = ~reset_n | stall | (m1_access & ~(gnt_valid & gnt_idx));
  end

  // Arbitration state freezes during stall so a burst resumes where it left off.
  always_ff @(posedge emesh_clk_inb) begin
    if (!reset_n) begin
      state <= IDLE;
      last  <= 1'b1;
      cnt   <= 8'd0;
    end else if (!stall) begin
      if (accept) begin
        last <= gnt_idx;
        if (state == (gnt_idx ? OWN1 : OWN0)) begin
          if (cnt != 8'hFF) begin
            cnt <= cnt + 8'd1;
          end
        end else begin
          state <= gnt_idx ? OWN1 : OWN0;
          cnt   <= 8'd1;
        end
      end else begin
        state <= IDLE;
        cnt   <= 8'd0;
      end
    end
  end

  always_ff @(posedge emesh_clk_inb) begin
    if (!reset_n) begin
      emesh_access_outb   <= 1'b0;
      emesh_write_outb    <= 1'b0;
      emesh_datamode_outb <= 2'd0;
      emesh_ctrlmode_outb <= 4'd0;
      emesh_dstaddr_outb  <= 32'd0;
      emesh_srcaddr_outb  <= 32'd0;
      emesh_data_outb     <= 32'd0;
    end else if (!stall) begin
      emesh_access_outb <= accept;
      if (accept) begin
        emesh_write_outb    <= gnt_idx ? m1_write    : m0_write;
        emesh_datamode_outb <= gnt_idx ? m1_datamode : m0_datamode;
        emesh_ctrlmode_outb <= gnt_idx ? m1_ctrlmode : m0_ctrlmode;
        emesh_dstaddr_outb  <= gnt_idx ? m1_dstaddr  : m0_dstaddr;
        emesh_srcaddr_outb  <= gnt_idx ? m1_srcaddr  : m0_srcaddr;
        emesh_data_outb     <= gnt_idx ? m1_data     : m0_data;
      end
    end
  end

  always_comb begin
    fsm_state = state;
    burst_cnt = cnt;
  end

endmodule

// File: tb/tb_ewrapper_emesh_arbiter.sv
// Randomized and directed bench for ewrapper_emesh_arbiter, checked against an
// ownership/run-length model and an expected-transaction queue.
module tb_ewrapper_emesh_arbiter;

  localparam int BURST = 4;

  typedef struct packed {
    logic        write;
    logic [1:0]  datamode;
    logic [3:0]  ctrlmode;
    logic [31:0] dst;
    logic [31:0] src;
    logic [31:0] data;
  } txn_t;

  logic        clk;
  logic        reset_n;
  logic        m0_access, m1_access;
  logic        m0_write, m1_write;
  logic [1:0]  m0_datamode, m1_datamode;
  logic [3:0]  m0_ctrlmode, m1_ctrlmode;
  logic [31:0] m0_dstaddr, m1_dstaddr;
  logic [31:0] m0_srcaddr, m1_srcaddr;
  logic [31:0] m0_data, m1_data;
  logic        m0_wait, m1_wait;
  logic        emesh_access_outb, emesh_write_outb;
  logic [1:0]  emesh_datamode_outb;
  logic [3:0]  emesh_ctrlmode_outb;
  logic [31:0] emesh_dstaddr_outb, emesh_srcaddr_outb, emesh_data_outb;
  logic        emesh_wr_wait_inb, emesh_rd_wait_inb;
  logic [1:0]  fsm_state;
  logic [7:0]  burst_cnt;

  ewrapper_emesh_arbiter #(.BURST_MAX(BURST)) dut (
    .emesh_clk_inb(clk),
    .reset_n(reset_n),
    .m0_access(m0_access), .m0_write(m0_write), .m0_datamode(m0_datamode),
    .m0_ctrlmode(m0_ctrlmode), .m0_dstaddr(m0_dstaddr), .m0_srcaddr(m0_srcaddr),
    .m0_data(m0_data), .m0_wait(m0_wait),
    .m1_access(m1_access), .m1_write(m1_write), .m1_datamode(m1_datamode),
    .m1_ctrlmode(m1_ctrlmode), .m1_dstaddr(m1_dstaddr), .m1_srcaddr(m1_srcaddr),
    .m1_data(m1_data), .m1_wait(m1_wait),
    .emesh_access_outb(emesh_access_outb), .emesh_write_outb(emesh_write_outb),
    .emesh_datamode_outb(emesh_datamode_outb), .emesh_ctrlmode_outb(emesh_ctrlmode_outb),
    .emesh_dstaddr_outb(emesh_dstaddr_outb), .emesh_srcaddr_outb(emesh_srcaddr_outb),
    .emesh_data_outb(emesh_data_outb),
    .emesh_wr_wait_inb(emesh_wr_wait_inb), .emesh_rd_wait_inb(emesh_rd_wait_inb),
    .fsm_state(fsm_state), .burst_cnt(burst_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- counters and checker ----------------
  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver state ----------------
  txn_t cur[2];
  logic have[2];
  int   left[2];
  int   pct[2];
  int   wmode[2];
  int   force_wr, force_rd, wait_pct;
  int   seq = 0;
  logic acc[2];

  // ---------------- reference model ----------------
  int   owner;
  int   run;
  logic last_m;
  logic ex_valid;
  txn_t ex;
  logic armed = 1'b0;
  txn_t exp_q[$];
  txn_t log_q[$];

  function automatic int pick(input logic a0, input logic a1);
    logic own_req, oth_req;
    if (owner < 0) begin
      if (a0 && a1) return last_m ? 0 : 1;
      if (a0) return 0;
      if (a1) return 1;
      return -1;
    end
    own_req = (owner == 0) ? a0 : a1;
    oth_req = (owner == 0) ? a1 : a0;
    if (own_req && (run < BURST || !oth_req)) return owner;
    if (oth_req) return 1 - owner;
    return -1;
  endfunction

  always @(negedge clk) begin
    logic stall_m, dut_stall;
    int   g;
    txn_t obs, e;
    stall_m = ex_valid & (ex.write ? emesh_wr_wait_inb : emesh_rd_wait_inb);
    g = pick(m0_access, m1_access);
    acc[0] = reset_n && !stall_m && g == 0;
    acc[1] = reset_n && !stall_m && g == 1;
    if (armed) begin
      check("m0_wait", 128'(m0_wait),
            128'(!reset_n || stall_m || (m0_access && g != 0)));
      check("m1_wait", 128'(m1_wait),
            128'(!reset_n || stall_m || (m1_access && g != 1)));
      check("out_regs",
            128'({emesh_access_outb, emesh_write_outb, emesh_datamode_outb,
                  emesh_ctrlmode_outb, emesh_dstaddr_outb, emesh_srcaddr_outb,
                  emesh_data_outb}),
            128'({ex_valid, ex}));
      check("state", 128'(fsm_state), 128'((owner < 0) ? 0 : owner + 1));
      check("cnt", 128'(burst_cnt), 128'((run > 255) ? 255 : run));
      dut_stall = emesh_access_outb &
                  (emesh_write_outb ? emesh_wr_wait_inb : emesh_rd_wait_inb);
      if (emesh_access_outb && !dut_stall) begin
        obs = {emesh_write_outb, emesh_datamode_outb, emesh_ctrlmode_outb,
               emesh_dstaddr_outb, emesh_srcaddr_outb, emesh_data_outb};
        log_q.push_back(obs);
        if (exp_q.size() == 0) begin
          check("sb_unexpected", 128'(1), 128'(0));
        end else begin
          e = exp_q.pop_front();
          check("sb_txn", 128'(obs), 128'(e));
        end
      end
    end
    // Advance the model to what the coming rising edge should produce.
    if (!reset_n) begin
      owner = -1; run = 0; last_m = 1'b1; ex_valid = 1'b0; ex = '0;
      exp_q.delete();
      armed = 1'b1;
    end else if (!stall_m) begin
      if (g >= 0) begin
        if (owner == g) run++;
        else begin
          owner = g;
          run = 1;
        end
        last_m = g[0];
        ex_valid = 1'b1;
        ex = cur[g];
        exp_q.push_back(cur[g]);
      end else begin
        owner = -1;
        run = 0;
        ex_valid = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_inputs();
    m0_access = have[0]; m0_write = cur[0].write; m0_datamode = cur[0].datamode;
    m0_ctrlmode = cur[0].ctrlmode; m0_dstaddr = cur[0].dst; m0_srcaddr = cur[0].src;
    m0_data = cur[0].data;
    m1_access = have[1]; m1_write = cur[1].write; m1_datamode = cur[1].datamode;
    m1_ctrlmode = cur[1].ctrlmode; m1_dstaddr = cur[1].dst; m1_srcaddr = cur[1].src;
    m1_data = cur[1].data;
  endtask

  task automatic apply_waits();
    emesh_wr_wait_inb = (force_wr >= 0) ? force_wr[0] : ($urandom_range(0, 99) < wait_pct);
    emesh_rd_wait_inb = (force_rd >= 0) ? force_rd[0] : ($urandom_range(0, 99) < wait_pct);
  endtask

  function automatic txn_t new_txn(input int i, input logic [31:0] dst, input int wm);
    txn_t t;
    t.write    = (wm == 2) ? 1'($urandom_range(0, 1)) : wm[0];
    t.datamode = 2'($urandom_range(0, 3));
    t.ctrlmode = 4'($urandom_range(0, 15));
    t.dst      = dst;
    t.src      = {8'(i), 24'(seq)};
    t.data     = $urandom;
    seq++;
    return t;
  endfunction

  task automatic set_txn(input int i, input logic [31:0] dst, input int wm);
    cur[i] = new_txn(i, dst, wm);
    have[i] = 1'b1;
    drive_inputs();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (have[i] && acc[i]) have[i] = 1'b0;
      if (!have[i] && left[i] > 0 && $urandom_range(0, 99) < pct[i]) begin
        cur[i] = new_txn(i, $urandom, wmode[i]);
        have[i] = 1'b1;
        left[i]--;
      end
    end
    apply_waits();
    drive_inputs();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [5:0] order;
    reset_n = 1'b0;
    force_wr = 0; force_rd = 0; wait_pct = 0;
    for (int i = 0; i < 2; i++) begin
      have[i] = 1'b0; left[i] = 0; pct[i] = 0; wmode[i] = 2; acc[i] = 1'b0;
      cur[i] = '0;
    end
    apply_waits();
    // Both requests held across reset; m0 must win the first tie.
    set_txn(0, 32'h100, 1);
    set_txn(1, 32'h200, 0);
    repeat (3) step();
    check("rst_access", 128'(emesh_access_outb), 128'(0));
    check("rst_waits", 128'({m0_wait, m1_wait}), 128'(2'b11));
    reset_n = 1'b1;
    repeat (6) step();
    check("t1_count", 128'(log_q.size()), 128'(2));
    if (log_q.size() >= 2) begin
      check("t1_first", 128'(log_q[0].dst), 128'(32'h100));
      check("t1_second", 128'(log_q[1].dst), 128'(32'h200));
    end

    // Burst fairness: m0 streams, m1 asks once.
    log_q.delete();
    left[0] = 20; pct[0] = 100; wmode[0] = 1;
    set_txn(0, 32'h1000, 1);
    set_txn(1, 32'h300, 1);
    repeat (40) step();
    order = '1;
    for (int k = 0; k < 6; k++) begin
      if (k < log_q.size()) order[5-k] = log_q[k].src[24];
    end
    check("t2_order", 128'(order), 128'(6'b000010));
    check("t2_count", 128'(log_q.size()), 128'(22));

    // Write stalled by wr_wait: nothing leaves until release.
    log_q.delete();
    left[0] = 0;
    force_wr = 1; force_rd = 0;
    set_txn(0, 32'h400, 1);
    step();
    set_txn(1, 32'h500, 0);
    repeat (6) step();
    check("t3_frozen", 128'(log_q.size()), 128'(0));
    check("t3_waits", 128'({m0_wait, m1_wait}), 128'(2'b11));
    force_wr = 0;
    apply_waits();
    repeat (5) step();
    check("t3_count", 128'(log_q.size()), 128'(2));
    if (log_q.size() >= 1) check("t3_first", 128'(log_q[0].dst), 128'(32'h400));

    // Read ignores wr_wait.
    log_q.delete();
    force_wr = 1; force_rd = 0;
    set_txn(0, 32'h600, 0);
    repeat (3) step();
    check("t4_count", 128'(log_q.size()), 128'(1));
    if (log_q.size() >= 1) check("t4_read", 128'({log_q[0].write, log_q[0].dst}), 128'({1'b0, 32'h600}));

    // Long single-requester stream: counter saturates, no gaps.
    log_q.delete();
    force_wr = 0; force_rd = 0;
    left[1] = 300; pct[1] = 100; wmode[1] = 2;
    repeat (280) step();
    check("t5_sat", 128'(burst_cnt), 128'(255));
    check("t5_owner", 128'(fsm_state), 128'(2));
    repeat (30) step();
    check("t5_count", 128'(log_q.size()), 128'(300));

    // Reset in the middle of a stall drops the stalled output only.
    log_q.delete();
    force_wr = 1; force_rd = 0;
    set_txn(0, 32'h700, 1);
    step();
    set_txn(0, 32'h710, 1);
    set_txn(1, 32'h720, 0);
    repeat (2) step();
    reset_n = 1'b0;
    step();
    check("t6_rst_access", 128'(emesh_access_outb), 128'(0));
    check("t6_rst_state", 128'(fsm_state), 128'(0));
    reset_n = 1'b1;
    force_wr = 0;
    apply_waits();
    repeat (6) step();
    check("t6_count", 128'(log_q.size()), 128'(2));
    if (log_q.size() >= 2) begin
      check("t6_first", 128'(log_q[0].dst), 128'(32'h710));
      check("t6_second", 128'(log_q[1].dst), 128'(32'h720));
    end

    // Random traffic with random back-pressure and occasional resets.
    force_wr = -1; force_rd = -1; wait_pct = 25;
    left[0] = 100000; left[1] = 100000;
    wmode[0] = 2; wmode[1] = 2;
    for (int blk = 0; blk < 4; blk++) begin
      pct[0] = $urandom_range(20, 100);
      pct[1] = $urandom_range(20, 100);
      for (int k = 0; k < 500; k++) begin
        step();
        reset_n = ($urandom_range(0, 299) != 0);
      end
    end

    // Drain: everything accepted must have been emitted.
    reset_n = 1'b1;
    left[0] = 0; left[1] = 0;
    force_wr = 0; force_rd = 0;
    apply_waits();
    repeat (20) step();
    check("drain_empty", 128'(exp_q.size()), 128'(0));
    check("drain_idle", 128'(fsm_state), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
